// File: rtl/inst_sram_responder.sv
// SRAM-like bus slave: queues up to MAX_OUTSTANDING requests, answers in order LATENCY cycles
// after each handshake from a word memory with byte/half/word writes; bp_addr stalls acceptance.
module inst_sram_responder #(
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [31:0]           rdata,
  input  logic                  bp_addr,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_idx,
  input  logic [31:0]           init_data
);

  localparam int SLOTS = 4;

  typedef enum logic {EMPTY, PENDING} slot_st_t;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           wdata;
    logic [3:0]            age;
  } ent_t;

  ent_t     ent_q [SLOTS];
  ent_t     ent_d [SLOTS];
  slot_st_t st_q  [SLOTS];
  slot_st_t st_d  [SLOTS];
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [2**DEPTH_LOG2];

  ent_t        head_ent;
  logic        accept, retire;
  logic [3:0]  be;
  logic [31:0] rd_word, wr_word;
  logic        unused_addr_hi;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  // Acceptance looks only at the registered count, so a full queue stalls even while its head retires.
  assign addr_ok  = !rst && !bp_addr && (cnt_q < 3'(MAX_OUTSTANDING));
  assign accept   = req && addr_ok;
  assign head_ent = ent_q[head_q];
  assign retire   = !rst && (st_q[head_q] == PENDING) && (head_ent.age == 4'd0);
  assign data_ok  = retire;
  assign rd_word  = mem[head_ent.idx];
  assign rdata    = rst ? 32'd0 : ((retire && !head_ent.wr) ? rd_word : rdata_q);

  always_comb begin
    be = 4'b0000;
    case (head_ent.size)
      2'd0:    be = 4'b0001 << head_ent.lane;
      2'd1:    be = head_ent.lane[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wr_word[8*b +: 8] = head_ent.wdata[8*b +: 8];
    end
  end

  always_comb begin
    ent_d   = ent_q;
    st_d    = st_q;
    head_d  = head_q;
    tail_d  = tail_q;
    rdata_d = rdata_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (st_q[i] == PENDING && ent_q[i].age != 4'd0) ent_d[i].age = ent_q[i].age - 4'd1;
    end
    if (retire) begin
      st_d[head_q] = EMPTY;
      head_d       = ptr_next(head_q);
      if (!head_ent.wr) rdata_d = rd_word;
    end
    // The tail slot can never be the retiring head: a full queue refuses new requests.
    if (accept) begin
      st_d[tail_q]  = PENDING;
      ent_d[tail_q] = '{wr: wr, size: size, idx: addr[DEPTH_LOG2+1:2], lane: addr[1:0],
                        wdata: wdata, age: 4'(LATENCY - 1)};
      tail_d        = ptr_next(tail_q);
    end
    cnt_d = cnt_q + 3'(accept) - 3'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '{default: '0};
      st_q    <= '{default: EMPTY};
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      ent_q   <= ent_d;
      st_q    <= st_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Preload is written last so it wins over a retiring write to the same word.
  always_ff @(posedge clk) begin
    if (retire && head_ent.wr) mem[head_ent.idx] <= wr_word;
    if (init_we) mem[init_idx] <= init_data;
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: table-driven transactions with an in-order scoreboard,
// plus hand-written backpressure, reset, init-collision and full-queue sequences.
module tb_inst_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req3 = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        bp_addr = 1'b0;
  logic        init_we = 1'b0;
  logic [9:0]  init_idx = 10'd0;
  logic [31:0] init_data = 32'd0;
  logic        addr_ok, data_ok, addr_ok3, data_ok3;
  logic [31:0] rdata, rdata3;

  always #5 clk = ~clk;

  inst_sram_responder #(.DEPTH_LOG2(10), .LATENCY(2), .MAX_OUTSTANDING(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .bp_addr(bp_addr),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data));

  inst_sram_responder #(.DEPTH_LOG2(10), .LATENCY(3), .MAX_OUTSTANDING(2)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok3), .data_ok(data_ok3), .rdata(rdata3), .bp_addr(bp_addr),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data));

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic        wr;
    logic [31:0] exp;
  } sb_t;

  vec_t        tbl [15];
  sb_t         sb [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] cur_exp = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  int          fq_aok [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
  int          fq_dok [12] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard for the LATENCY=2 instance: occupancy predicts addr_ok, queue head predicts data_ok/rdata.
  always @(negedge clk) begin : mon
    logic eaok, edok;
    eaok = !rst && !bp_addr && (sb.size() < 2);
    check("addr_ok", 32'(addr_ok), 32'(eaok));
    edok = 1'b0;
    if (rst) begin
      sb.delete();
      exp_rdata = 32'd0;
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      edok = 1'b1;
      if (!sb[0].wr) exp_rdata = sb[0].exp;
      void'(sb.pop_front());
    end
    check("data_ok", 32'(data_ok), 32'(edok));
    check("rdata", rdata, exp_rdata);
    if (req && eaok) sb.push_back('{due: cyc + 2, wr: wr, exp: cur_exp});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    int w;
    wr = v.wr; size = v.size; addr = v.addr; wdata = v.wdata; cur_exp = v.exp;
    req = 1'b1;
    w = 0;
    @(negedge clk);
    while (!addr_ok && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (w >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: addr %h not accepted in 50 cycles", v.addr);
    end
    tick();
    req = 1'b0;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    init_idx = idx; init_data = d; init_we = 1'b1;
    tick();
    init_we = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 32'hbfc0_0000, 32'h0,         32'h3c08_bfc0};
    tbl[1]  = '{1'b0, 2'd2, 32'hbfc0_0004, 32'h0,         32'h2508_0010};
    tbl[2]  = '{1'b1, 2'd0, 32'hbfc0_0011, 32'h5566_AA77, 32'h0};
    tbl[3]  = '{1'b1, 2'd1, 32'hbfc0_0012, 32'hBEEF_9999, 32'h0};
    tbl[4]  = '{1'b0, 2'd2, 32'hbfc0_0010, 32'h0,         32'hBEEF_AA44};
    tbl[5]  = '{1'b1, 2'd2, 32'h0000_0020, 32'hCAFE_F00D, 32'h0};
    tbl[6]  = '{1'b0, 2'd0, 32'h0000_0022, 32'h0,         32'hCAFE_F00D};
    tbl[7]  = '{1'b1, 2'd3, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 2'd0, 32'h0000_0023, 32'h5A11_1111, 32'h0};
    tbl[10] = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'h5AFE_F00D};
    tbl[11] = '{1'b1, 2'd1, 32'h0000_0020, 32'h7777_1234, 32'h0};
    tbl[12] = '{1'b0, 2'd0, 32'h0000_0021, 32'h0,         32'h5AFE_1234};
    tbl[13] = '{1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'h3c08_bfc0};
    tbl[14] = '{1'b0, 2'd2, 32'h0000_0FFC, 32'h0,         32'hA5A5_0FF0};

    repeat (3) tick();
    rst = 1'b0;
    preload(10'd0, 32'h3c08_bfc0);
    preload(10'd1, 32'h2508_0010);
    preload(10'd4, 32'h1122_3344);
    preload(10'd1023, 32'hA5A5_0FF0);
    tick();

    for (int i = 0; i < 15; i++) send(tbl[i]);
    drain();

    // Backpressure holds off a pending request, then it is taken the cycle bp_addr drops.
    wr = 1'b0; size = 2'd2; addr = 32'hbfc0_0000; cur_exp = 32'h3c08_bfc0;
    bp_addr = 1'b1;
    req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold[%0d]", k), 32'(addr_ok), 32'd0);
      tick();
    end
    bp_addr = 1'b0;
    @(negedge clk);
    check("bp_release", 32'(addr_ok), 32'd1);
    tick();
    req = 1'b0;
    drain();

    // Reset with two reads in flight: neither may respond.
    send('{1'b0, 2'd2, 32'h0000_0004, 32'h0, 32'h2508_0010});
    send('{1'b0, 2'd2, 32'h0000_0000, 32'h0, 32'h3c08_bfc0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_addr_ok", 32'(addr_ok), 32'd1);
    repeat (5) tick();

    // Retiring write and preload hit word 7 in the same cycle; preload must stick.
    send('{1'b1, 2'd2, 32'h0000_001C, 32'hDEAD_BEEF, 32'h0});
    tick();
    init_idx = 10'd7; init_data = 32'h1234_5678; init_we = 1'b1;
    @(negedge clk);
    check("collision_data_ok", 32'(data_ok), 32'd1);
    tick();
    init_we = 1'b0;
    send('{1'b0, 2'd2, 32'h0000_001C, 32'h0, 32'h1234_5678});
    drain();

    // Full queue on the LATENCY=3 instance with req held high.
    wr = 1'b0; size = 2'd2; addr = 32'h0000_0000;
    req3 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("fq_addr_ok[%0d]", k), 32'(addr_ok3), 32'(fq_aok[k]));
      check($sformatf("fq_data_ok[%0d]", k), 32'(data_ok3), 32'(fq_dok[k]));
      if (fq_dok[k] != 0) check($sformatf("fq_rdata[%0d]", k), rdata3, 32'h3c08_bfc0);
      tick();
    end
    req3 = 1'b0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

SRAM-like bus responder: the slave end of the handshake that the fetch stage drives. It accepts req/addr handshakes, queues up to MAX_OUTSTANDING transactions, and returns in-order responses after a fixed LATENCY. Responses are served from an internal word-addressed memory. It sits opposite the CPU instruction port in the SoC and core testbenches, and is also reusable on the data port because it supports byte, half and word writes.

## Interface
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- LATENCY, 2: cycles from handshake to data_ok; legal range 1..8.
- MAX_OUTSTANDING, 2: queue depth; legal range 1..4.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  master request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word.
- addr  in  32  byte address; word index = addr[DEPTH_LOG2+1:2]; upper bits ignored (kseg1 0xbfc00000 aliases index 0).
- wdata  in  32  write data, lane-aligned as on the bus.
- addr_ok  out  1  request accepted this cycle when req is also high.
- data_ok  out  1  one-cycle response pulse.
- rdata  out  32  read data, valid while data_ok is high.
- bp_addr  in  1  bench backpressure; forces addr_ok low.
- init_we  in  1  preload write strobe.
- init_idx  in  DEPTH_LOG2  preload word index.
- init_data  in  32  preload word.

## Operation
- addr_ok = !rst && !bp_addr && (count < MAX_OUTSTANDING). It is combinational from the registered count and must not depend on req.
- Count excludes the entry retiring in the same cycle. A full queue therefore deasserts addr_ok even while the head retires.
- Handshake: req && addr_ok sampled at a rising edge. The bus fields {wr, size, addr, wdata} are captured into the queue tail along with an age counter set to LATENCY-1.
- Every queued entry's age decrements each cycle and saturates at 0.
- The head entry retires in the cycle its age is 0. In that cycle data_ok is high, the entry is popped at the following edge, and the next entry becomes head.
- Responses are strictly in acceptance order, with at most one retirement per cycle.
- Read retire: rdata = mem[index] as of that cycle, so earlier writes are visible. A full word is returned regardless of size and addr[1:0]. rdata holds its value when data_ok is low.
- Write retire: memory updates at the edge ending the data_ok cycle. Byte enables:
  - size 0: lane addr[1:0].
  - size 1: lanes {addr[1],0} and {addr[1],1}.
  - size 2: all lanes.
  - size 3: no lanes written; still responds.
- On a write, rdata is left unchanged.
- Preload: init_we writes mem[init_idx] = init_data at the edge. If a retiring write targets the same index in the same cycle, init wins.
- A handshake and a retirement in the same cycle are both honoured, and count is updated by net +0.
- No internal state machine beyond the queue. Per-entry state is EMPTY or PENDING, with a head pointer, tail pointer and count.

## Timing
- A handshake in cycle t produces data_ok high in cycle t+LATENCY, for each request independently.
- Back-to-back accepted requests produce back-to-back data_ok pulses.
- Reset: count = 0, all entries EMPTY, data_ok = 0, rdata = 0, addr_ok = 0 while rst is high.
- Memory contents are not reset.
- Reset mid-operation discards all pending entries. No data_ok occurs after rst is sampled high, and writes still pending are lost.
- When the queue is full with LATENCY ≥ MAX_OUTSTANDING, throughput falls below 1 per cycle. The master sees addr_ok low and must hold req, addr and the other bus fields stable.

## Test plan
- **Preload read:** preload idx 0 = 0x3c08bfc0, idx 1 = 0x25080010. Issue reads at 0xbfc00000 and 0xbfc00004 in consecutive cycles t and t+1 (LATENCY = 2). Expect data_ok in t+2 and t+3 with rdata 0x3c08bfc0 then 0x25080010.
- **Full queue:** MAX_OUTSTANDING = 2, LATENCY = 3, req held high continuously. Expect addr_ok low in the cycle after 2 acceptances, until the head retires. The third handshake lands exactly one cycle after the first data_ok, and data_ok never pulses twice per cycle.
- **Byte/half writes:** idx 4 starts at 0x11223344.
  - Write byte 0xAA at addr 0x...11.
  - Then half 0xBEEF at addr 0x...12.
  - Then read 0x...10.
  - Expect rdata 0xBEEFAA44, with all three responses in order.
- **Backpressure:** assert bp_addr for 5 cycles with req high. Expect addr_ok = 0 and no acceptance. On release, addr_ok is 1 in the same cycle and data_ok follows LATENCY cycles later.
- **Reset mid-flight:** accept 2 reads, then assert rst for 1 cycle before either retires. Expect no data_ok, rdata = 0, count = 0, and addr_ok = 1 in the first cycle after rst deasserts.
- **Init collision:** a write retire to idx 7 (0xDEADBEEF) coincides with init_we to idx 7 (0x12345678). A later read of idx 7 returns 0x12345678.
